// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// alu_issue_stage
//
// Sequential wrapper around a combinational 4-bit ALU (3-bit opcode, 5-bit
// result). One request is taken over a valid/ready handshake, its operands
// and opcode are registered onto the ALU inputs, the ALU is given one full
// cycle to settle, and the captured result is then offered downstream over a
// second valid/ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holds its payload stable
// while valid=1 and ready=0. Here in_ready and out_valid come from state
// registers only; neither depends combinationally on in_valid or out_ready.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : request handshake
//   in_a, in_b      : 4-bit operands
//   in_sel          : 3-bit ALU opcode (passed through, never decoded here)
//   in_acc          : 1 = take operand A from the accumulator
//   alu_a/b/sel     : registered ALU inputs
//   alu_r           : 5-bit ALU result (combinational, from the ALU)
//   out_valid/ready : result handshake
//   out_result      : captured ALU result
//   out_zero        : out_result == 0
//   out_carry       : out_result[4] (carry / borrow / shift-out)
//   op_count        : number of results handed off, wraps
//   dbg_state       : current FSM state (IDLE=0, EXEC=1, DONE=2)
// ----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [2:0]       in_sel,
    input  logic             in_acc,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [4:0]       alu_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [3:0]       alu_a_q;
    logic [3:0]       alu_b_q;
    logic [2:0]       alu_sel_q;
    logic [4:0]       result_q;
    logic             zero_q;
    logic             carry_q;
    logic [3:0]       acc_q;
    logic [CNT_W-1:0] cnt_q;

    // Operand A selection at acceptance; in_acc matters only here.
    logic [3:0] opa_d;
    assign opa_d = in_acc ? acc_q : in_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_sel_q   <= 3'd0;
            result_q    <= 5'd0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            acc_q       <= 4'd0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_a_q    <= opa_d;
                        alu_b_q    <= in_b;
                        alu_sel_q  <= in_sel;
                        in_ready_q <= 1'b0;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle: capture.
                    // The accumulator follows every EXEC, handed off or not.
                    result_q    <= alu_r;
                    zero_q      <= (alu_r == 5'd0);
                    carry_q     <= alu_r[4];
                    acc_q       <= alu_r[3:0];
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_carry  = carry_q;
    assign op_count   = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_sel;
  logic       in_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [4:0] alu_r;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_result;
  logic       out_zero;
  logic       out_carry;
  logic [7:0] op_count;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_cnt;
  logic [4:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_acc(in_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // Reference combinational ALU driving alu_r.
  always_comb begin
    alu_r = 5'd0;
    case (alu_sel)
      3'd0: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_r = {1'b0, alu_a & alu_b};
      3'd3: alu_r = {1'b0, alu_a | alu_b};
      3'd4: alu_r = {alu_a, 1'b0};
      3'd5: alu_r = {2'b00, alu_a[3:1]};
      3'd6: alu_r = {1'b0, alu_a[2:0], alu_a[3]};
      default: alu_r = {1'b0, alu_a[0], alu_a[3:1]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction; called at a negedge with the DUT in IDLE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                        input logic acc, input logic [3:0] exp_a, input logic [4:0] exp_res,
                        input logic hand_off);
    logic [4:0] exp_r;
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel; in_acc = acc;
    exp_q.push_back(exp_res);
    @(negedge clk);
    in_valid = 1'b0; in_acc = 1'b0; in_a = 4'h0;
    check("exec_state", 32'(dbg_state), 32'd1);
    check("exec_out_valid", 32'(out_valid), 32'd0);
    check("exec_in_ready", 32'(in_ready), 32'd0);
    check("alu_a", 32'(alu_a), 32'(exp_a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_sel", 32'(alu_sel), 32'(sel));
    @(negedge clk);
    exp_r = exp_q.pop_front();
    check("done_out_valid", 32'(out_valid), 32'd1);
    check("done_state", 32'(dbg_state), 32'd2);
    check("result", 32'(out_result), 32'(exp_r));
    check("zero", 32'(out_zero), 32'(exp_r == 5'd0));
    check("carry", 32'(out_carry), 32'(exp_r[4]));
    if (hand_off) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      check("count_after_handoff", 32'(op_count), 32'(exp_cnt));
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_a = 4'h7; in_b = 4'h2; in_sel = 3'd0; in_acc = 1'b0;
    out_ready = 1'b0; exp_cnt = 8'd0;

    // Reset held 2 cycles with in_valid=1.
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd1);
    check("rst_carry", 32'(out_carry), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_no_accept", 32'(dbg_state), 32'd0);

    // Add with carry out: F+1 = 0x10.
    run_op(4'hF, 4'h1, 3'd0, 1'b0, 4'hF, 5'h10, 1'b1);
    // Subtract wrap: 3-5 = 0x1E; 5-5 = 0.
    run_op(4'h3, 4'h5, 3'd1, 1'b0, 4'h3, 5'h1E, 1'b1);
    run_op(4'h5, 4'h5, 3'd1, 1'b0, 4'h5, 5'h00, 1'b1);
    // Shift / rotate on 0x9.
    run_op(4'h9, 4'h0, 3'd4, 1'b0, 4'h9, 5'h12, 1'b1);
    run_op(4'h9, 4'h0, 3'd5, 1'b0, 4'h9, 5'h04, 1'b1);
    run_op(4'h9, 4'h0, 3'd6, 1'b0, 4'h9, 5'h03, 1'b1);
    run_op(4'h9, 4'h0, 3'd7, 1'b0, 4'h9, 5'h0C, 1'b1);
    // Accumulate chain: 2+3=5, then acc(5)+1=6.
    run_op(4'h2, 4'h3, 3'd0, 1'b0, 4'h2, 5'h05, 1'b1);
    run_op(4'hF, 4'h1, 3'd0, 1'b1, 4'h5, 5'h06, 1'b1);

    // Backpressure: 6+1=7 held in DONE while a new request waits.
    run_op(4'h6, 4'h1, 3'd0, 1'b0, 4'h6, 5'h07, 1'b0);
    in_valid = 1'b1; in_a = 4'hA; in_b = 4'hA; in_sel = 3'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", 32'(out_result), 32'h07);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_count", 32'(op_count), 32'(exp_cnt));
      check("bp_alu_a", 32'(alu_a), 32'h6);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("bp_release_count", 32'(op_count), 32'(exp_cnt));
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_held_not_taken", 32'(alu_a), 32'h6);

    // Backpressure again, then reset while in DONE: 1+1=2.
    run_op(4'h1, 4'h1, 3'd0, 1'b0, 4'h1, 5'h02, 1'b0);
    @(negedge clk);
    check("bp2_count", 32'(op_count), 32'(exp_cnt));
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    exp_cnt = 8'd0;
    check("rst_done_out_valid", 32'(out_valid), 32'd0);
    check("rst_done_count", 32'(op_count), 32'd0);
    check("rst_done_in_ready", 32'(in_ready), 32'd1);
    check("rst_done_result", 32'(out_result), 32'd0);
    // Accumulator cleared by reset: acc(0)+0 = 0.
    run_op(4'hF, 4'h0, 3'd0, 1'b1, 4'h0, 5'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
